// File: rtl/frac_div_monitor.sv
// frac_div_monitor: measures a divided clock that is synchronous to CLK_in.
// Over a gate window of GATE_CYC CLK_in cycles it counts rising edges of DIV_clk
// and tracks the minimum and maximum edge-to-edge period in CLK_in cycles.
// The gate is aligned to the first DIV_clk rising edge after start (the arming edge),
// and that edge is not counted.
// Optional build macro: FRAC_DIV_MONITOR_SYNC_IN_EN inserts a 2-flop synchronizer on
// DIV_clk ahead of the edge detector. Use it when DIV_clk comes from another clock source.
module frac_div_monitor #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned GATE_CYC = 1000
) (
    input  logic             CLK_in,
    input  logic             RST,
    input  logic             DIV_clk,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] min_per,
    output logic [CNT_W-1:0] max_per
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] GateLast = CNT_W'(GATE_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeas,
        StDone
    } state_e;

    state_e           state_q;
    logic             div_s;
    logic             d_q;
    logic             rise;
    logic [CNT_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] edge_inc;

`ifdef FRAC_DIV_MONITOR_SYNC_IN_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer for an asynchronous DIV_clk source
    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= DIV_clk;
            sync2_q <= sync1_q;
        end
    end

    assign div_s = sync2_q;
`else
    assign div_s = DIV_clk;
`endif

    // Previous-sample register for the rising-edge detector
    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            d_q <= 1'b0;
        end else begin
            d_q <= div_s;
        end
    end

    // Rising edge is evaluated every cycle regardless of state
    always_comb begin
        rise     = div_s & ~d_q;
        per_inc  = (per_cnt_q == CntMax) ? per_cnt_q : per_cnt_q + CntOne;
        edge_inc = (edge_cnt  == CntMax) ? edge_cnt  : edge_cnt  + CntOne;
    end

    // Measurement FSM with registered status and result outputs
    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            edge_cnt   <= '0;
            min_per    <= CntMax;
            max_per    <= '0;
            gate_cnt_q <= '0;
            per_cnt_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        edge_cnt   <= '0;
                        err        <= 1'b0;
                        max_per    <= '0;
                        min_per    <= CntMax;
                        gate_cnt_q <= '0;
                        busy       <= 1'b1;
                        state_q    <= StArm;
                    end
                end

                StArm: begin
                    if (rise) begin
                        // Arming edge aligns the gate; it is a period start, not a count
                        per_cnt_q  <= CntOne;
                        gate_cnt_q <= '0;
                        state_q    <= StMeas;
                    end else if (gate_cnt_q == GateLast) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + CntOne;
                    end
                end

                StMeas: begin
                    gate_cnt_q <= gate_cnt_q + CntOne;
                    if (rise) begin
                        edge_cnt <= edge_inc;
                        if (per_cnt_q < min_per) begin
                            min_per <= per_cnt_q;
                        end
                        if (per_cnt_q > max_per) begin
                            max_per <= per_cnt_q;
                        end
                        per_cnt_q <= CntOne;
                    end else begin
                        per_cnt_q <= per_inc;
                    end
                    // Edges in the last gate cycle are still counted above
                    if (gate_cnt_q == GateLast) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end

                StDone: begin
                    // Start is only accepted from idle, so a start here is dropped
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frac_div_monitor.sv
// Self-checking bench for frac_div_monitor. DIV_clk waveforms are built as per-cycle
// arrays; the reference model finds rising edges in the array and derives the arming
// edge, the gate window, the edge count, the period extremes and the done cycle.
module tb_frac_div_monitor;

    localparam int unsigned CW = 16;
    localparam int GA = 1000;
    localparam int GB = 500;

    logic clk     = 1'b0;
    logic RST     = 1'b0;
    logic DIV_clk = 1'b0;
    logic start   = 1'b0;
    logic sel     = 1'b0;

    logic start_a, start_b;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [CW-1:0] cnt_a, min_a, max_a, cnt_b, min_b, max_b;
    logic busy_m, done_m, err_m;
    logic [CW-1:0] cnt_m, min_m, max_m;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign busy_m  = sel ? busy_b : busy_a;
    assign done_m  = sel ? done_b : done_a;
    assign err_m   = sel ? err_b  : err_a;
    assign cnt_m   = sel ? cnt_b  : cnt_a;
    assign min_m   = sel ? min_b  : min_a;
    assign max_m   = sel ? max_b  : max_a;

    frac_div_monitor #(.CNT_W(CW), .GATE_CYC(GA)) dut_a (
        .CLK_in(clk), .RST(RST), .DIV_clk(DIV_clk), .start(start_a),
        .busy(busy_a), .done(done_a), .err(err_a),
        .edge_cnt(cnt_a), .min_per(min_a), .max_per(max_a)
    );

    frac_div_monitor #(.CNT_W(CW), .GATE_CYC(GB)) dut_b (
        .CLK_in(clk), .RST(RST), .DIV_clk(DIV_clk), .start(start_b),
        .busy(busy_b), .done(done_b), .err(err_b),
        .edge_cnt(cnt_b), .min_per(min_b), .max_per(max_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit wave[$];
    int starts[$];
    int rlo = -1;
    int rhi = -1;
    bit busy_log[$];
    int done_at;
    int ndone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rise_at(input int t);
        return wave[t] && !wave[t-1];
    endfunction

    // Reference: arming edge is the first rise in the ARM window; counted edges lie in
    // the GATE cycles after it; periods are distances between consecutive rises.
    task automatic model(input int s, input int g, output int dk, output int cnt,
                         output int mn, output int mx, output bit er);
        int a = -1;
        int prev;
        for (int t = s + 1; t <= s + g; t++) begin
            if (a < 0 && rise_at(t)) a = t;
        end
        cnt = 0;
        mn  = 32'hFFFF;
        mx  = 0;
        if (a < 0) begin
            er = 1'b1;
            dk = s + 1 + g;
            return;
        end
        er   = 1'b0;
        prev = a;
        for (int t = a + 1; t <= a + g; t++) begin
            if (rise_at(t)) begin
                cnt++;
                if (t - prev < mn) mn = t - prev;
                if (t - prev > mx) mx = t - prev;
                prev = t;
            end
        end
        dk = a + g + 1;
    endtask

    task automatic drive(input int len);
        busy_log.delete();
        done_at = -1;
        ndone   = 0;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            DIV_clk = wave[k];
            start   = 1'b0;
            foreach (starts[i]) if (starts[i] == k) start = 1'b1;
            RST = !(k >= rlo && k < rhi);
            @(negedge clk);
            busy_log.push_back(busy_m);
            if (done_m === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
        end
        start = 1'b0;
        starts.delete();
        rlo = -1;
        rhi = -1;
    endtask

    task automatic check_run(input string tag, input int s, input int g);
        int dk, cnt, mn, mx;
        bit er;
        model(s, g, dk, cnt, mn, mx, er);
        chk({tag, ".done_cycle"}, done_at, dk);
        chk({tag, ".done_pulses"}, ndone, 1);
        chk({tag, ".err"}, {31'd0, err_m}, {31'd0, er});
        chk({tag, ".edge_cnt"}, {16'd0, cnt_m}, cnt);
        chk({tag, ".min_per"}, {16'd0, min_m}, mn);
        chk({tag, ".max_per"}, {16'd0, max_m}, mx);
        chk({tag, ".busy_after_start"}, {31'd0, busy_log[s+1]}, 1);
        chk({tag, ".busy_at_done"}, {31'd0, busy_log[dk]}, 0);
    endtask

    task automatic gen_div4(input int len, input int ph);
        wave.delete();
        for (int k = 0; k < len; k++) wave.push_back(((k + ph) % 4) >= 2);
        wave[0] = 1'b0;
    endtask

    task automatic gen_dither(input int len, input int ph);
        bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        wave.delete();
        for (int k = 0; k < len; k++) wave.push_back(pat[(k + ph) % 5]);
        wave[0] = 1'b0;
    endtask

    task automatic gen_rand(input int len);
        int lo, hi;
        wave.delete();
        wave.push_back(1'b0);
        while (wave.size() < len) begin
            lo = $urandom_range(1, 4);
            hi = $urandom_range(1, 5);
            for (int i = 0; i < lo; i++) wave.push_back(1'b0);
            for (int i = 0; i < hi; i++) wave.push_back(1'b1);
        end
        while (wave.size() > len) void'(wave.pop_back());
    endtask

    task automatic gen_zero(input int len);
        wave.delete();
        for (int k = 0; k < len; k++) wave.push_back(1'b0);
    endtask

    initial begin
        int s, len, dk, cnt, mn, mx, a;
        bit er;

        // Reset held while start toggles
        sel = 1'b0;
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 start = ~start;
        end
        @(negedge clk);
        chk("rst.busy", {31'd0, busy_a}, 0);
        chk("rst.done", {31'd0, done_a}, 0);
        chk("rst.err", {31'd0, err_a}, 0);
        chk("rst.edge_cnt", {16'd0, cnt_a}, 0);
        chk("rst.min_per", {16'd0, min_a}, 32'hFFFF);
        chk("rst.max_per", {16'd0, max_a}, 0);
        chk("rst.busy_b", {31'd0, busy_b}, 0);
        @(posedge clk);
        #1 start = 1'b0;
        RST = 1'b1;

        // Steady divide-by-4, gate 1000
        sel = 1'b0;
        s   = $urandom_range(2, 9);
        len = s + GA + 20;
        gen_div4(len, $urandom_range(0, 3));
        starts.push_back(s);
        drive(len);
        check_run("div4", s, GA);
        chk("div4.cnt250", {16'd0, cnt_m}, 250);
        chk("div4.min4", {16'd0, min_m}, 4);
        chk("div4.max4", {16'd0, max_m}, 4);

        // Dithered 2/3 periods, gate 500
        sel = 1'b1;
        s   = $urandom_range(2, 9);
        len = s + GB + 20;
        gen_dither(len, $urandom_range(0, 4));
        starts.push_back(s);
        drive(len);
        check_run("dither", s, GB);
        chk("dither.cnt200", {16'd0, cnt_m}, 200);
        chk("dither.min2", {16'd0, min_m}, 2);
        chk("dither.max3", {16'd0, max_m}, 3);

        // No edges: timeout sets err
        s   = $urandom_range(2, 9);
        len = s + GB + 20;
        gen_zero(len);
        starts.push_back(s);
        drive(len);
        check_run("noedge", s, GB);
        chk("noedge.err1", {31'd0, err_m}, 1);
        chk("noedge.err_held", {31'd0, err_b}, 1);

        // Extra starts mid-MEAS and in the done cycle are ignored
        sel = 1'b0;
        s   = $urandom_range(2, 9);
        len = s + GA + 40;
        gen_div4(len, $urandom_range(0, 3));
        model(s, GA, dk, cnt, mn, mx, er);
        starts.push_back(s);
        starts.push_back(s + 400);
        starts.push_back(dk);
        drive(dk + 10);
        check_run("busystart", s, GA);
        chk("busystart.cnt250", {16'd0, cnt_m}, 250);
        chk("busystart.idle1", {31'd0, busy_log[dk+1]}, 0);
        chk("busystart.idle5", {31'd0, busy_log[dk+5]}, 0);

        // Reset asserted at gate cycle 300 for 10 cycles
        s   = $urandom_range(2, 9);
        len = s + GA + 40;
        gen_div4(len, $urandom_range(0, 3));
        model(s, GA, dk, cnt, mn, mx, er);
        a   = dk - GA - 1;
        rlo = a + 301;
        rhi = rlo + 10;
        starts.push_back(s);
        drive(dk + 10);
        chk("midrst.no_done", ndone, 0);
        chk("midrst.busy_in_rst", {31'd0, busy_log[a+305]}, 0);
        chk("midrst.busy_after", {31'd0, busy_m}, 0);
        chk("midrst.err", {31'd0, err_m}, 0);
        chk("midrst.edge_cnt", {16'd0, cnt_m}, 0);
        chk("midrst.min_per", {16'd0, min_m}, 32'hFFFF);
        chk("midrst.max_per", {16'd0, max_m}, 0);

        // Full run after the mid-run reset
        s   = $urandom_range(2, 9);
        len = s + GA + 20;
        gen_div4(len, $urandom_range(0, 3));
        starts.push_back(s);
        drive(len);
        check_run("postrst", s, GA);

        // Random edge patterns, gate 500
        sel = 1'b1;
        for (int r = 0; r < 3; r++) begin
            s   = $urandom_range(2, 9);
            len = s + GB + 30;
            gen_rand(len);
            starts.push_back(s);
            drive(len);
            check_run($sformatf("rand%0d", r), s, GB);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
